// File: rtl/optic_flow_pkg.sv
// Shared constants and types for the optic-flow encode custom instruction.
package optic_flow_pkg;

  localparam int NUM_PIXELS = 4;
  localparam int PIX_W      = 8;
  localparam int NIB_W      = 4;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_POS  = 2'b01;
  localparam logic [1:0] CODE_NEG  = 2'b10;

  // Nibble layout: {temporal[1:0], horizontal[1:0]}
  localparam int TEMP_LSB = 2;
  localparam int HORZ_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CLR  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/optic_flow_encode_ci_pixel_classify.sv
// Combinational per-pixel classifier: temporal and horizontal motion codes.
module optic_flow_pixel_classify
  import optic_flow_pkg::*;
(
  input  logic [7:0] cur,
  input  logic [7:0] prev,
  input  logic [7:0] left,
  input  logic       leftValid,
  input  logic [7:0] threshold,
  output logic [3:0] code
);

  logic [8:0] it;
  logic [8:0] ix;
  logic [8:0] it_abs;
  logic [8:0] ix_abs;
  logic       it_sig;
  logic       ix_sig;
  logic [1:0] temporal;
  logic [1:0] horizontal;

  always_comb begin
    it     = {1'b0, cur} - {1'b0, prev};
    ix     = {1'b0, cur} - {1'b0, left};
    it_abs = it[8] ? (9'd0 - it) : it;
    ix_abs = ix[8] ? (9'd0 - ix) : ix;
    it_sig = it_abs > {1'b0, threshold};
    ix_sig = ix_abs > {1'b0, threshold};

    temporal = CODE_NONE;
    if (it_sig) temporal = it[8] ? CODE_NEG : CODE_POS;

    // Opposite signs of It and Ix mean the edge is moving right.
    horizontal = CODE_NONE;
    if (it_sig && ix_sig && leftValid) horizontal = (it[8] != ix[8]) ? CODE_POS : CODE_NEG;

    code = '0;
    code[TEMP_LSB +: 2] = temporal;
    code[HORZ_LSB +: 2] = horizontal;
  end

endmodule

// File: rtl/optic_flow_encode_ci.sv
// Multi-cycle optic-flow encode CI: one pixel per clock through a shared classifier.
module optic_flow_encode_ci
  import optic_flow_pkg::*;
#(
  parameter logic [7:0] customInstructionId = 8'd29,
  parameter logic [7:0] clearInstructionId  = 8'd31,
  parameter logic [7:0] defaultThreshold    = 8'd8
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  cnt;
  logic [1:0]  cnt_m1;
  logic [31:0] cur_q;
  logic [31:0] prev_q;
  logic [15:0] codes;
  logic [7:0]  left_pixel;
  logic        left_valid;
  logic [7:0]  threshold;
  logic [7:0]  new_threshold;

  logic [7:0]  pix_cur;
  logic [7:0]  pix_prev;
  logic [7:0]  pix_left;
  logic        pix_left_valid;
  logic [3:0]  nibble;

  logic        go_encode;
  logic        go_clear;

  assign go_encode = (state == IDLE) && start && (ciN == customInstructionId);
  assign go_clear  = (state == IDLE) && start && (ciN == clearInstructionId);

  always_comb begin
    cnt_m1         = cnt - 2'd1;
    pix_cur        = cur_q[{cnt, 3'b000} +: 8];
    pix_prev       = prev_q[{cnt, 3'b000} +: 8];
    pix_left       = (cnt == 2'd0) ? left_pixel : cur_q[{cnt_m1, 3'b000} +: 8];
    pix_left_valid = (cnt == 2'd0) ? left_valid : 1'b1;
  end

  optic_flow_pixel_classify u_classify (
    .cur       (pix_cur),
    .prev      (pix_prev),
    .left      (pix_left),
    .leftValid (pix_left_valid),
    .threshold (threshold),
    .code      (nibble)
  );

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    result    = '0;
    case (state)
      IDLE: begin
        if (go_encode)     state_nxt = CALC;
        else if (go_clear) state_nxt = CLR;
      end
      CALC: if (cnt == 2'd3) state_nxt = DONE;
      CLR:  state_nxt = DONE;
      DONE: begin
        state_nxt = IDLE;
        done      = 1'b1;
        result    = {16'h0000, codes};
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      cnt           <= 2'd0;
      cur_q         <= '0;
      prev_q        <= '0;
      codes         <= '0;
      left_pixel    <= '0;
      left_valid    <= 1'b0;
      threshold     <= defaultThreshold;
      new_threshold <= defaultThreshold;
    end else begin
      if (go_encode) begin
        cur_q  <= valueA;
        prev_q <= valueB;
        cnt    <= 2'd0;
        codes  <= '0;
      end
      if (go_clear) new_threshold <= valueA[7:0];
      if (state == CALC) begin
        codes[{cnt, 2'b00} +: 4] <= nibble;
        cnt                      <= cnt + 2'd1;
        if (cnt == 2'd3) begin
          left_pixel <= cur_q[31:24];
          left_valid <= 1'b1;
        end
      end
      if (state == CLR) begin
        left_valid <= 1'b0;
        threshold  <= new_threshold;
        codes      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_optic_flow_encode_ci.sv
// Scoreboard bench for optic_flow_encode_ci: directed cases, boundaries, busy/reset handling, random encodes.
module tb_optic_flow_encode_ci;

  logic        clock = 1'b0;
  logic        nReset;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int start_cyc = 0;
  int d0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  // Reference model state
  int m_left;
  bit m_lv;
  int m_thr;

  logic [31:0] r;
  logic [31:0] ra;
  logic [31:0] rb;

  optic_flow_encode_ci dut (
    .clock  (clock),
    .nReset (nReset),
    .start  (start),
    .ciN    (ciN),
    .valueA (valueA),
    .valueB (valueB),
    .done   (done),
    .result (result)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (nReset === 1'b1) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) check("spurious_done", 32'd1, 32'd0);
        else begin
          check("result", result, exp_q.pop_front());
          check("latency", cyc - start_cyc, lat_q.pop_front());
        end
      end else begin
        check("result_idle", result, 32'd0);
      end
    end
  end

  task automatic model_encode(input logic [31:0] a, input logic [31:0] b, output logic [31:0] res);
    int cur, prv, lft, it, ix, t, h;
    bit lv;
    res = 32'd0;
    for (int i = 0; i < 4; i++) begin
      cur = int'(a[8*i +: 8]);
      prv = int'(b[8*i +: 8]);
      lft = (i == 0) ? m_left : int'(a[8*(i-1) +: 8]);
      lv  = (i == 0) ? m_lv : 1'b1;
      it  = cur - prv;
      ix  = cur - lft;
      t = 0;
      h = 0;
      if (it > m_thr) t = 1;
      else if (it < -m_thr) t = 2;
      if (lv && (it > m_thr || it < -m_thr) && (ix > m_thr || ix < -m_thr))
        h = ((it > 0) == (ix > 0)) ? 2 : 1;
      res = res | (32'(t * 4 + h) << (4 * i));
    end
    m_left = int'(a[31:24]);
    m_lv   = 1'b1;
  endtask

  task automatic issue(input logic [7:0] n, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start     = 1'b1;
    ciN       = n;
    valueA    = a;
    valueB    = b;
    start_cyc = cyc + 1;
    @(negedge clock);
    start  = 1'b0;
    ciN    = 8'($urandom_range(0, 255));
    valueA = $urandom;
    valueB = $urandom;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("timeout", exp_q.size(), 32'd0);
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  task automatic do_clear(input logic [7:0] thr);
    exp_q.push_back(32'd0);
    lat_q.push_back(1);
    m_lv  = 1'b0;
    m_thr = int'(thr);
    issue(8'd31, {24'($urandom), thr}, $urandom);
    wait_empty();
  endtask

  task automatic encode_chk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] unused_r;
    model_encode(a, b, unused_r);
    exp_q.push_back(exp);
    lat_q.push_back(4);
    issue(8'd29, a, b);
    wait_empty();
  endtask

  task automatic encode_rand(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mr;
    model_encode(a, b, mr);
    exp_q.push_back(mr);
    lat_q.push_back(4);
    issue(8'd29, a, b);
    wait_empty();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    nReset = 1'b0;
    start  = 1'b0;
    ciN    = 8'd0;
    valueA = 32'd0;
    valueB = 32'd0;
    m_left = 0;
    m_lv   = 1'b0;
    m_thr  = 8;

    repeat (3) @(negedge clock);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    nReset = 1'b1;

    // Unknown ciN with start high, then start low with the encode ciN
    @(negedge clock);
    start  = 1'b1;
    ciN    = 8'd47;
    valueA = 32'h80808080;
    valueB = 32'h40404040;
    repeat (6) @(negedge clock);
    start = 1'b0;
    ciN   = 8'd29;
    repeat (6) @(negedge clock);
    check("idle_no_done", done_cnt, 32'd0);

    do_clear(8'd8);
    encode_chk(32'h40404040, 32'h40404040, 32'h00000000);
    do_clear(8'd8);
    encode_chk(32'h80808080, 32'h40404040, 32'h00004444);
    do_clear(8'd8);
    encode_chk(32'h90901010, 32'h90101010, 32'h00000600);
    encode_chk(32'h10101010, 32'h90909090, 32'h0000888A);

    do_clear(8'h50);
    encode_chk(32'h60606060, 32'h10101010, 32'h00000000);
    do_clear(8'h4F);
    encode_chk(32'h60606060, 32'h10101010, 32'h00004444);

    do_clear(8'd0);
    encode_chk(32'h05040302, 32'h05040302, 32'h00000000);
    repeat (3) encode_rand($urandom, $urandom);
    do_clear(8'd255);
    encode_chk(32'hFF00FF00, 32'h00FF00FF, 32'h00000000);

    // Starts arriving while busy must be dropped
    do_clear(8'd8);
    d0 = done_cnt;
    ra = $urandom;
    rb = $urandom;
    model_encode(ra, rb, r);
    exp_q.push_back(r);
    lat_q.push_back(4);
    issue(8'd29, ra, rb);
    @(negedge clock);
    start  = 1'b1;
    ciN    = 8'd29;
    valueA = $urandom;
    @(negedge clock);
    ciN    = 8'd31;
    valueA = 32'h000000FF;
    @(negedge clock);
    start = 1'b0;
    wait_empty();
    repeat (4) @(negedge clock);
    check("busy_one_done", done_cnt - d0, 32'd1);

    // Abort in the middle of CALC (pixel counter 2)
    issue(8'd29, 32'h10101010, 32'h90909090);
    repeat (2) @(negedge clock);
    nReset = 1'b0;
    #1;
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    m_left = 0;
    m_lv   = 1'b0;
    m_thr  = 8;
    d0     = done_cnt;
    @(negedge clock);
    nReset = 1'b1;
    repeat (8) @(negedge clock);
    check("no_done_after_reset", done_cnt - d0, 32'd0);
    encode_chk(32'h10101010, 32'h90909090, 32'h00008888);

    for (int k = 0; k < 15; k++) begin
      if ($urandom_range(0, 3) == 0) do_clear(8'($urandom_range(0, 40)));
      encode_rand($urandom, $urandom);
    end

    wait_empty();
    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/optic_flow_encode_ci.md
Name: optic_flow_encode_ci

Overview:
- Multi-cycle custom instruction that produces the 4-bit-per-pixel optic-flow codes consumed by the optic-flow colour CI. That CI expands one code byte into two RGB565 pixels.
- Compares 4 current-frame grayscale pixels against the same 4 pixels from the previous frame. Uses a stored left neighbour carried between calls.
- Sits on the CPU custom-instruction bus beside the colour CI. Software packs the 16-bit result as two code bytes for the colour CI.

Parameters:
- customInstructionId, 8'd29, ciN value that runs the encode operation.
- clearInstructionId, 8'd31, ciN value that clears the left neighbour and loads the threshold.
- defaultThreshold, 8'd8, threshold value after reset.

Ports:
- clock  in  1  system clock.
- nReset  in  1  asynchronous active-low reset.
- start  in  1  CI start strobe.
- ciN  in  8  CI number.
- valueA  in  32  encode: current pixels, pixel i = valueA[8i+7:8i], pixel 0 leftmost. Clear: new threshold in [7:0].
- valueB  in  32  encode: previous-frame pixels, same packing. Clear: ignored.
- done  out  1  one-cycle completion pulse.
- result  out  32  codes while done is high, otherwise 0.

Behaviour:
- Reset (asynchronous, nReset low) sets:
  - done=0, result=0, state IDLE, pixel counter 0;
  - leftValid=0, leftPixel=0, threshold=defaultThreshold.
- Reset asserted mid-operation aborts the operation. No done pulse follows.
- States:
  - IDLE: start&&ciN==customInstructionId → latch valueA/valueB, counter=0, go to CALC. start&&ciN==clearInstructionId → go to CLR. Any other ciN, or start low → stay in IDLE.
  - CALC: one pixel per clock, counter 0..3. After pixel 3 → DONE.
  - CLR: leftValid=0, threshold=valueA[7:0] as latched at start → DONE with result 0.
  - DONE: done=1 and result driven for exactly one cycle → IDLE.
- Latency:
  - encode: done high in the 5th cycle after the edge that samples start;
  - clear: done high in the 2nd cycle after that edge.
- start while not in IDLE is ignored. No queuing.
- Per-pixel arithmetic (9-bit signed differences, no saturation):
  - It = cur[i] − prev[i];
  - Ix = cur[i] − left, where left = cur[i−1], or leftPixel for i=0.
- Significance test is strictly greater than threshold: |It|>threshold, |Ix|>threshold.
- Code nibble for pixel i is result[4i+3:4i] = {temporal[1:0], horizontal[1:0]}:
  - temporal: 01 if It>+threshold; 10 if It<−threshold; else 00.
  - horizontal: 00 unless both |It| and |Ix| are significant and the left neighbour is valid. Then 01 (moving right) if It and Ix have opposite signs, 10 (moving left) if they have the same sign.
  - Code 11 is never produced.
- Left-neighbour validity: pixel 0 uses leftPixel only if leftValid=1. Pixels 1..3 always have a valid left neighbour.
- After each encode: leftPixel=cur[3], leftValid=1.
- result[31:16]=0 always.
- Threshold 0 is legal: any nonzero difference is significant.
- Threshold 255 disables all codes, since |diff| ≤ 255.

Decomposition:
- Package optic_flow_pkg holds:
  - the 2-bit code constants (CODE_NONE, CODE_POS, CODE_NEG);
  - the state enum (IDLE, CALC, CLR, DONE);
  - nibble field positions.
- One combinational sub-module, optic_flow_pixel_classify:
  - inputs: cur, prev, left, leftValid, threshold;
  - output: 4-bit code nibble;
  - instantiated once and time-multiplexed by the counter.

Test Plan:
- Idle and other-ciN behaviour: after reset, start=1 with ciN=47 → done never rises, result=0. start=0 with ciN=29 → same.
- Static frame: clear (valueA=8), then encode A=0x40404040, B=0x40404040 → done for one cycle at the 5th cycle, result=0x00000000.
- Brightening: clear (valueA=8), then A=0x80808080, B=0x40404040 → result=0x00004444. Pixel 0 horizontal is 00 because the left neighbour is invalid.
- Edge moving left, then darkening:
  - clear, then A=0x90901010, B=0x90101010 → result=0x00000600;
  - next encode A=0x10101010, B=0x90909090, with leftPixel=0x90 → result=0x0000888A.
- Threshold boundary: clear with valueA=0x50, then A=0x60606060, B=0x10101010 (It=+80, not >80) → result=0. Repeat with threshold 0x4F → 0x00004444.
- Reset and busy handling:
  - second start during CALC is ignored and exactly one done occurs;
  - nReset pulsed low while counter=2 → done=0 and result=0 immediately;
  - no done follows the reset, and the next encode treats pixel 0's left neighbour as invalid.
